// File: rtl/bru_pkg.sv
// bru_pkg: shared entry layout and defaults for branch_resolve_unit.
// pred_target exists only with BRU_TARGET_CHECK_EN defined.
package bru_pkg;
   localparam int DEPTH_DEF = 8;
   localparam int IDX_W_DEF = 6;
   localparam logic [31:0] PC_INC = 32'd4;
   typedef struct packed {
      logic valid;
      logic resolved;
      logic [31:0] pc;
      logic pred_taken;
`ifdef BRU_TARGET_CHECK_EN
      logic [31:0] pred_target;
`endif
      logic act_taken;
      logic [31:0] act_target;
   } entry_t;
endpackage

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order retirement of out-of-order resolved branches with mispredict flush.
// BRU_TARGET_CHECK_EN adds a taken-target comparison to the mispredict test.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic [31:0]                alloc_pc,
   input  logic                       alloc_pred_taken,
   input  logic [31:0]                alloc_pred_target,
   output logic [$clog2(DEPTH)-1:0]   alloc_tag,
   input  logic                       res_valid,
   input  logic [$clog2(DEPTH)-1:0]   res_tag,
   input  logic                       res_taken,
   input  logic [31:0]                res_target,
   output logic                       upd_valid,
   output logic [IDX_W-1:0]           upd_idx,
   output logic                       upd_taken,
   output logic                       flush,
   output logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int TW = $clog2(DEPTH);
   localparam int CW = TW + 1;
   entry_t ents [DEPTH];
   entry_t hd;
   logic [TW-1:0] head, tail;
   logic retire, mis, alloc_fire, res_fire;
   assign hd = ents[head];
   assign alloc_ready = (count < CW'(DEPTH)) && !flush;
   assign alloc_tag = tail;
   assign alloc_fire = alloc_valid && alloc_ready;
   assign res_fire = res_valid && !flush && ents[res_tag].valid && !ents[res_tag].resolved;
   // the flush cycle must not retire younger entries
   assign retire = !flush && hd.valid && hd.resolved;
`ifdef BRU_TARGET_CHECK_EN
   assign mis = (hd.act_taken != hd.pred_taken) ||
                (hd.act_taken && hd.pred_taken && hd.act_target != hd.pred_target);
`else
   logic unused_target;
   assign unused_target = ^alloc_pred_target;
   assign mis = hd.act_taken != hd.pred_taken;
`endif
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ents[i].valid <= 1'b0;
            ents[i].resolved <= 1'b0;
         end
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (alloc_fire) begin
            ents[tail].valid <= 1'b1;
            ents[tail].resolved <= 1'b0;
            ents[tail].pc <= alloc_pc;
            ents[tail].pred_taken <= alloc_pred_taken;
`ifdef BRU_TARGET_CHECK_EN
            ents[tail].pred_target <= alloc_pred_target;
`endif
            tail <= tail + TW'(1);
         end
         if (res_fire) begin
            ents[res_tag].resolved <= 1'b1;
            ents[res_tag].act_taken <= res_taken;
            ents[res_tag].act_target <= res_target;
         end
         if (retire) begin
            ents[head].valid <= 1'b0;
            head <= head + TW'(1);
         end
         count <= count + CW'(alloc_fire) - CW'(retire);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         upd_valid <= 1'b0;
         upd_idx <= '0;
         upd_taken <= 1'b0;
         flush <= 1'b0;
         redirect_pc <= '0;
      end else begin
         upd_valid <= retire;
         upd_idx <= retire ? hd.pc[IDX_W+1:2] : '0;
         upd_taken <= retire && hd.act_taken;
         flush <= retire && mis;
         if (retire && mis) redirect_pc <= hd.act_taken ? hd.act_target : hd.pc + PC_INC;
      end
   end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus multi-cycle sequences for branch_resolve_unit.
module tb_branch_resolve_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, alloc_valid, alloc_ready, alloc_pred_taken, res_valid, res_taken;
   logic upd_valid, upd_taken, flush;
   logic [31:0] alloc_pc, alloc_pred_target, res_target, redirect_pc;
   logic [2:0] alloc_tag, res_tag;
   logic [5:0] upd_idx;
   logic [3:0] count;
   int checks = 0, failures = 0;
`ifdef BRU_TARGET_CHECK_EN
   localparam bit TC = 1'b1;
`else
   localparam bit TC = 1'b0;
`endif
   branch_resolve_unit dut (
      .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_pc(alloc_pc), .alloc_pred_taken(alloc_pred_taken), .alloc_pred_target(alloc_pred_target),
      .alloc_tag(alloc_tag), .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
      .res_target(res_target), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .flush(flush), .redirect_pc(redirect_pc), .count(count)
   );
   typedef struct {
      logic [31:0] pc;
      logic pt;
      logic [31:0] ptgt;
      logic rt;
      logic [31:0] rtgt;
      logic exp_flush;
      logic [31:0] exp_redir;
      logic [5:0] exp_idx;
   } vec_t;
   vec_t vecs [6];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", n, a, e);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      reset = 1'b1;
      alloc_valid = 1'b0;
      res_valid = 1'b0;
      tick;
      tick;
      reset = 1'b0;
   endtask
   task automatic alloc(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
      alloc_valid = 1'b1;
      alloc_pc = pc;
      alloc_pred_taken = pt;
      alloc_pred_target = ptgt;
   endtask
   task automatic resolve(input logic [2:0] t, input logic tk, input logic [31:0] tg);
      res_valid = 1'b1;
      res_tag = t;
      res_taken = tk;
      res_target = tg;
   endtask
   initial begin
      logic [2:0] exp_tag;
      logic [31:0] last_redir;
      vecs[0] = '{32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h00};
      vecs[1] = '{32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h204, 6'h00};
      vecs[2] = '{32'h1234, 1'b1, 32'h1300, 1'b1, 32'h1300, 1'b0, 32'h0, 6'h0D};
      vecs[3] = '{32'h3F8, 1'b0, 32'h0, 1'b1, 32'h5000, 1'b1, 32'h5000, 6'h3E};
      vecs[4] = '{32'h300, 1'b1, 32'h400, 1'b1, 32'h480, TC, 32'h480, 6'h00};
      vecs[5] = '{32'hFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 6'h3F};
      alloc_pc = '0; alloc_pred_taken = 1'b0; alloc_pred_target = '0;
      res_tag = '0; res_taken = 1'b0; res_target = '0;
      reset = 1'b1; alloc_valid = 1'b0; res_valid = 1'b0;
      tick;
      chk("rst_upd_valid", 32'(upd_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("rst_upd_idx", 32'(upd_idx), 32'd0);
      do_reset;
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      exp_tag = 3'd0;
      last_redir = 32'd0;
      for (int i = 0; i < 6; i++) begin
         tick;
         alloc(vecs[i].pc, vecs[i].pt, vecs[i].ptgt);
         chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'd1);
         chk($sformatf("v%0d_tag", i), 32'(alloc_tag), 32'(exp_tag));
         tick;
         alloc_valid = 1'b0;
         resolve(exp_tag, vecs[i].rt, vecs[i].rtgt);
         tick;
         res_valid = 1'b0;
         chk($sformatf("v%0d_upd_early", i), 32'(upd_valid), 32'd0);
         tick;
         if (vecs[i].exp_flush) last_redir = vecs[i].exp_redir;
         chk($sformatf("v%0d_upd_valid", i), 32'(upd_valid), 32'd1);
         chk($sformatf("v%0d_upd_idx", i), 32'(upd_idx), 32'(vecs[i].exp_idx));
         chk($sformatf("v%0d_upd_taken", i), 32'(upd_taken), 32'(vecs[i].rt));
         chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].exp_flush));
         chk($sformatf("v%0d_redirect", i), redirect_pc, last_redir);
         exp_tag = vecs[i].exp_flush ? 3'd0 : exp_tag + 3'd1;
         tick;
         chk($sformatf("v%0d_flush_end", i), 32'(flush), 32'd0);
         chk($sformatf("v%0d_count", i), 32'(count), 32'd0);
         chk($sformatf("v%0d_ready_end", i), 32'(alloc_ready), 32'd1);
      end
      // out-of-order resolution retires in tag order
      do_reset;
      for (int i = 0; i < 3; i++) begin
         tick;
         alloc(32'h10 * (i + 1), 1'b0, 32'h0);
      end
      tick;
      alloc_valid = 1'b0;
      resolve(3'd2, 1'b0, 32'h0);
      tick;
      resolve(3'd1, 1'b0, 32'h0);
      tick;
      resolve(3'd0, 1'b0, 32'h0);
      tick;
      res_valid = 1'b0;
      chk("ooo_upd_early", 32'(upd_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("ooo_upd%0d_valid", i), 32'(upd_valid), 32'd1);
         chk($sformatf("ooo_upd%0d_idx", i), 32'(upd_idx), 32'(4 * (i + 1)));
      end
      tick;
      chk("ooo_upd_end", 32'(upd_valid), 32'd0);
      chk("ooo_count", 32'(count), 32'd0);
      // full queue, retire with alloc held high
      do_reset;
      for (int i = 0; i < 8; i++) begin
         tick;
         alloc(32'h1010 + 32'(i * 4), 1'b0, 32'h0);
      end
      tick;
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd8);
      resolve(3'd0, 1'b0, 32'h0);
      tick;
      res_valid = 1'b0;
      chk("full_retire_ready", 32'(alloc_ready), 32'd0);
      chk("full_retire_count", 32'(count), 32'd8);
      tick;
      chk("full_after_count", 32'(count), 32'd7);
      chk("full_after_ready", 32'(alloc_ready), 32'd1);
      chk("full_after_tag", 32'(alloc_tag), 32'd0);
      chk("full_after_upd", 32'(upd_valid), 32'd1);
      chk("full_after_idx", 32'(upd_idx), 32'h04);
      tick;
      alloc_valid = 1'b0;
      chk("full_refill_count", 32'(count), 32'd8);
      chk("full_refill_ready", 32'(alloc_ready), 32'd0);
      // flush with resolved younger entries and a simultaneous alloc
      do_reset;
      tick;
      alloc(32'h200, 1'b1, 32'h300);
      tick;
      alloc(32'h40, 1'b0, 32'h0);
      tick;
      alloc(32'h80, 1'b0, 32'h0);
      tick;
      alloc_valid = 1'b0;
      resolve(3'd1, 1'b0, 32'h0);
      tick;
      resolve(3'd2, 1'b0, 32'h0);
      tick;
      resolve(3'd0, 1'b0, 32'h0);
      tick;
      res_valid = 1'b0;
      chk("fl_upd_early", 32'(upd_valid), 32'd0);
      tick;
      alloc(32'h900, 1'b0, 32'h0);
      chk("fl_flush", 32'(flush), 32'd1);
      chk("fl_upd_valid", 32'(upd_valid), 32'd1);
      chk("fl_redirect", redirect_pc, 32'h204);
      chk("fl_alloc_ready", 32'(alloc_ready), 32'd0);
      tick;
      alloc_valid = 1'b0;
      chk("fl_young_upd", 32'(upd_valid), 32'd0);
      chk("fl_flush_end", 32'(flush), 32'd0);
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_alloc_tag", 32'(alloc_tag), 32'd0);
      tick;
      chk("fl_young_upd2", 32'(upd_valid), 32'd0);
      // reset in the retire cycle suppresses the pending flush
      do_reset;
      tick;
      alloc(32'h200, 1'b1, 32'h300);
      tick;
      alloc_valid = 1'b0;
      resolve(3'd0, 1'b0, 32'h0);
      tick;
      res_valid = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rov_flush", 32'(flush), 32'd0);
      chk("rov_upd", 32'(upd_valid), 32'd0);
      tick;
      chk("rov_flush2", 32'(flush), 32'd0);
      chk("rov_upd2", 32'(upd_valid), 32'd0);
      chk("rov_count", 32'(count), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
